acc_sram_rmw_ctrl: RTL and testbench



---
 rtl/acc_sram_rmw_ctrl_pkg.sv | 17 +
 rtl/acc_sram_rmw_ctrl_sat_add.sv | 34 +++
 rtl/acc_sram_rmw_ctrl.sv | 117 +++++++++++
 tb/tb_acc_sram_rmw_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_sram_rmw_ctrl_pkg.sv
// Shared widths, state encoding and word type for the accumulator SRAM controller.
package acc_sram_rmw_ctrl_pkg;

  localparam int ACC_AW = 11;
  localparam int ACC_DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    ACC_RD,
    ACC_WR,
    OUT_RD,
    OUT_HOLD
  } acc_ctrl_state_e;

  typedef logic signed [ACC_DW-1:0] acc_word_t;

endpackage

// File: rtl/acc_sram_rmw_ctrl_sat_add.sv
// Purpose: signed accumulate adder; wraps by default, saturates under ACC_SATURATE_EN.
// Latency: combinational. Backpressure: none.
module acc_sat_add
  import acc_sram_rmw_ctrl_pkg::*;
(
  input  acc_word_t a_i,
  input  acc_word_t b_i,
  output acc_word_t sum_o
);

  acc_word_t raw_sum;
  assign raw_sum = a_i + b_i;

`ifdef ACC_SATURATE_EN
  logic ovf_pos;
  logic ovf_neg;

  // Overflow only when both operands share a sign that the result does not.
  assign ovf_pos = !a_i[ACC_DW-1] && !b_i[ACC_DW-1] &&  raw_sum[ACC_DW-1];
  assign ovf_neg =  a_i[ACC_DW-1] &&  b_i[ACC_DW-1] && !raw_sum[ACC_DW-1];

  always_comb begin
    sum_o = raw_sum;
    if (ovf_pos) begin
      sum_o = {1'b0, {(ACC_DW-1){1'b1}}};
    end else if (ovf_neg) begin
      sum_o = {1'b1, {(ACC_DW-1){1'b0}}};
    end
  end
`else
  assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/acc_sram_rmw_ctrl.sv
// Purpose: read-modify-write controller for the 2048x32 accumulator SRAM plus readout port (ACC_SATURATE_EN selects saturating add).
// Latency: first-write commits 1 edge after accept, accumulate 2 edges; readout data valid 2 edges after accept.
// Backpressure: in_ready drops during ACC_RD/OUT_*; readout stalls on in_valid; out_ready low holds OUT_HOLD with SRAM idle.
module acc_sram_rmw_ctrl
  import acc_sram_rmw_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ACC_AW-1:0] in_addr_i,
  input  logic [ACC_DW-1:0] in_data_i,
  input  logic              in_first_i,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  input  logic [ACC_AW-1:0] rd_addr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ACC_DW-1:0] out_data_o,
  output logic              sram_ceb_o,
  output logic              sram_web_o,
  output logic [ACC_AW-1:0] sram_a_o,
  output logic [ACC_DW-1:0] sram_d_o,
  input  logic [ACC_DW-1:0] sram_q_i
);

  acc_ctrl_state_e   state_q, state_d;
  logic [ACC_AW-1:0] addr_q, addr_d;
  acc_word_t         data_q, data_d;
  logic              first_q, first_d;
  logic [ACC_AW-1:0] rd_addr_q, rd_addr_d;
  acc_word_t         sum;

  acc_sat_add u_sat_add (
    .a_i   (acc_word_t'(sram_q_i)),
    .b_i   (data_q),
    .sum_o (sum)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      first_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      first_q   <= first_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    first_d     = first_q;
    rd_addr_d   = rd_addr_q;
    in_ready_o  = 1'b0;
    rd_ready_o  = 1'b0;
    sram_ceb_o  = 1'b1;
    sram_web_o  = 1'b1;
    sram_a_o    = '0;
    sram_d_o    = '0;
    out_valid_o = 1'b0;
    out_data_o  = '0;

    case (state_q)
      ACC_RD: begin
        sram_ceb_o = 1'b0;
        sram_a_o   = addr_q;
        state_d    = ACC_WR;
      end
      ACC_WR: begin
        sram_ceb_o = 1'b0;
        sram_web_o = 1'b0;
        sram_a_o   = addr_q;
        sram_d_o   = first_q ? data_q : sum;
        state_d    = IDLE;
      end
      OUT_RD: begin
        sram_ceb_o = 1'b0;
        sram_a_o   = rd_addr_q;
        state_d    = OUT_HOLD;
      end
      OUT_HOLD: begin
        // Q holds its value because the SRAM is not enabled here.
        out_valid_o = 1'b1;
        out_data_o  = sram_q_i;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
      end
    endcase

    // ACC_WR accepts like IDLE so first-writes stream at one per cycle.
    if (state_q == IDLE || state_q == ACC_WR) begin
      in_ready_o = 1'b1;
      rd_ready_o = !in_valid_i;
      if (in_valid_i) begin
        addr_d  = in_addr_i;
        data_d  = acc_word_t'(in_data_i);
        first_d = in_first_i;
        state_d = in_first_i ? ACC_WR : ACC_RD;
      end else if (rd_valid_i) begin
        rd_addr_d = rd_addr_i;
        state_d   = OUT_RD;
      end
    end
  end

endmodule

// File: tb/tb_acc_sram_rmw_ctrl.sv
// Directed bench for acc_sram_rmw_ctrl with a behavioural single-port SRAM model.
module tb_acc_sram_rmw_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_first;
  logic [10:0] in_addr;
  logic [31:0] in_data;
  logic        rd_valid, rd_ready;
  logic [10:0] rd_addr;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        ceb, web;
  logic [10:0] sa;
  logic [31:0] sd, sq;
  logic [31:0] mem [0:2047];

  int n_chk = 0;
  int n_err = 0;

`ifdef ACC_SATURATE_EN
  localparam logic [31:0] EXP_POS = 32'h7FFFFFFF;
  localparam logic [31:0] EXP_NEG = 32'h80000000;
`else
  localparam logic [31:0] EXP_POS = 32'h80000010;
  localparam logic [31:0] EXP_NEG = 32'h7FFFFFF5;
`endif

  acc_sram_rmw_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_addr_i   (in_addr),
    .in_data_i   (in_data),
    .in_first_i  (in_first),
    .rd_valid_i  (rd_valid),
    .rd_ready_o  (rd_ready),
    .rd_addr_i   (rd_addr),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .sram_ceb_o  (ceb),
    .sram_web_o  (web),
    .sram_a_o    (sa),
    .sram_d_o    (sd),
    .sram_q_i    (sq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!ceb) begin
      if (!web) mem[sa] <= sd;
      else      sq      <= mem[sa];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Call in the low phase; returns at the negedge after the accepting edge.
  task automatic acc_op(input logic [10:0] a, input logic [31:0] dat, input logic f);
    bit done = 0;
    in_valid = 1'b1; in_addr = a; in_data = dat; in_first = f;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (in_ready) done = 1;
      @(negedge clk);
    end
    in_valid = 1'b0; in_first = 1'b0;
    if (!done) chk("acc_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_read(input string tag, input logic [10:0] a, input logic [31:0] exp);
    bit done = 0;
    rd_valid = 1'b1; rd_addr = a;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (rd_ready) done = 1;
      @(negedge clk);
    end
    rd_valid = 1'b0;
    if (!done) chk("rd_timeout", 32'd0, 32'd1);
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (out_valid) done = 1;
      else @(negedge clk);
    end
    if (!done) chk("out_timeout", 32'd0, 32'd1);
    chk(tag, out_data, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  bit exp_rdy [7] = '{1, 1, 0, 1, 0, 1, 0};
  logic [31:0] vals [4] = '{32'd0, 32'd1, 32'd2, 32'd3};

  initial begin
    int idx;
    rst_n = 1'b0; in_valid = 0; in_first = 0; in_addr = '0; in_data = '0;
    rd_valid = 0; rd_addr = '0; out_ready = 0;
    #12;
    chk("rst_ceb", 32'(ceb), 32'd1);
    chk("rst_web", 32'(web), 32'd1);
    chk("rst_a", 32'(sa), 32'd0);
    chk("rst_d", sd, 32'd0);
    chk("rst_oval", 32'(out_valid), 32'd0);
    chk("rst_odat", out_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("idle_in_rdy", 32'(in_ready), 32'd1);
    chk("idle_rd_rdy", 32'(rd_ready), 32'd1);

    // First write then accumulate on address 5.
    @(negedge clk);
    acc_op(11'd5, 32'd10, 1'b1);
    #1;
    chk("fw_ceb", 32'(ceb), 32'd0);
    chk("fw_web", 32'(web), 32'd0);
    chk("fw_a", 32'(sa), 32'd5);
    chk("fw_d", sd, 32'd10);
    @(negedge clk); #1;
    chk("fw_done_ceb", 32'(ceb), 32'd1);
    @(negedge clk);
    acc_op(11'd5, -32'sd3, 1'b0);
    #1;
    chk("ar_ceb", 32'(ceb), 32'd0);
    chk("ar_web", 32'(web), 32'd1);
    chk("ar_a", 32'(sa), 32'd5);
    chk("ar_in_rdy", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    chk("aw_web", 32'(web), 32'd0);
    chk("aw_d", sd, 32'd7);
    @(negedge clk);
    do_read("rd_addr5", 11'd5, 32'd7);

    // Streaming: first 0 then +1,+2,+3 to address 100.
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      if (idx < 4) begin
        in_valid = 1'b1; in_addr = 11'd100; in_data = vals[idx]; in_first = (idx == 0);
      end else begin
        in_valid = 1'b0; in_first = 1'b0;
      end
      #1;
      chk($sformatf("b2b_rdy%0d", c), 32'(in_ready), 32'(exp_rdy[c]));
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0; in_first = 1'b0;
    do_read("rd_addr100", 11'd100, 32'd6);

    // Simultaneous requests, then a readout held off by out_ready.
    @(negedge clk);
    in_valid = 1'b1; in_addr = 11'd200; in_data = 32'd55; in_first = 1'b1;
    rd_valid = 1'b1; rd_addr = 11'd5;
    #1;
    chk("both_rd_rdy", 32'(rd_ready), 32'd0);
    chk("both_in_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0;
    #1;
    chk("after_rd_rdy", 32'(rd_ready), 32'd1);
    @(negedge clk);
    rd_valid = 1'b0;
    #1;
    chk("ord_ceb", 32'(ceb), 32'd0);
    chk("ord_a", 32'(sa), 32'd5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk($sformatf("hold_val%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("hold_dat%0d", c), out_data, 32'd7);
      chk($sformatf("hold_ceb%0d", c), 32'(ceb), 32'd1);
    end
    chk("hold_in_rdy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("hold_release", 32'(out_valid), 32'd0);
    @(negedge clk);
    do_read("rd_addr200", 11'd200, 32'd55);

    // Overflow at both address extremes.
    acc_op(11'd2047, 32'h7FFFFFF0, 1'b1);
    acc_op(11'd2047, 32'h00000020, 1'b0);
    do_read("ovf_pos", 11'd2047, EXP_POS);
    acc_op(11'd0, 32'h80000005, 1'b1);
    acc_op(11'd0, 32'hFFFFFFF0, 1'b0);
    do_read("ovf_neg", 11'd0, EXP_NEG);

    // Reset asserted while in ACC_RD.
    acc_op(11'd300, 32'd100, 1'b1);
    acc_op(11'd300, 32'd4, 1'b0);
    #1;
    chk("pre_rst_ceb", 32'(ceb), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ceb", 32'(ceb), 32'd1);
    chk("mid_rst_web", 32'(web), 32'd1);
    chk("mid_rst_a", 32'(sa), 32'd0);
    chk("mid_rst_d", sd, 32'd0);
    chk("mid_rst_in_rdy", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    acc_op(11'd300, 32'd9, 1'b1);
    acc_op(11'd300, 32'd1, 1'b0);
    do_read("post_rst", 11'd300, 32'd10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
